// File: rtl/demuxpri.sv
// rtl/demuxpri.sv - priority demultiplexer with registered per-channel output slots
module demuxpri #(
    parameter int DW = 32,
    parameter int N  = 2,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_sel,
    input  logic [DW-1:0]   in_data,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            hit,
    output logic [CW-1:0]   drop_count
);

    logic [N-1:0] win_oh;
    logic [N-1:0] load;
    logic         any_sel;
    logic         slot_free;
    logic         accept;

    // Isolate the lowest set select bit as the one-hot winner and derive ready/accept.
    // Only the winner's slot is consulted: a busy winner stalls the input rather
    // than falling through to a higher channel.
    always_comb begin
        win_oh    = in_sel & (~in_sel + N'(1));
        any_sel   = |in_sel;
        slot_free = |(win_oh & (~out_valid | out_ready));
        in_ready  = !rst && (!any_sel || slot_free);
        accept    = in_valid && in_ready;
        load      = accept ? win_oh : '0;
    end

    // Output slots: a load beats a same-cycle drain so a channel can stream one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i]) begin
                    out_valid[i]          <= 1'b1;
                    out_data[i*DW +: DW]  <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i]          <= 1'b0;
                end
            end
        end
    end

    // Hit pulse for routed accepts and saturating count of words accepted with no select bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit        <= 1'b0;
            drop_count <= '0;
        end else begin
            hit <= accept && any_sel;
            if (accept && !any_sel && (drop_count != {CW{1'b1}}))
                drop_count <= drop_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_demuxpri.sv
// tb/tb_demuxpri.sv - self-checking bench for demuxpri
module tb_demuxpri;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [63:0] out_data;
    logic        hit;
    logic [1:0]  drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    demuxpri #(.DW(32), .N(2), .CW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .hit        (hit),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [1:0]  ordy;
        logic        rdy;
        logic [1:0]  ov;
        logic        hit;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  dc;
    } vec_t;

    vec_t tbl [15];

    // reference model state
    logic        mv [2];
    logic [31:0] md [2];
    int          mdc;
    logic        mhit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] data,
                         input logic [1:0] ordy);
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    // Model: compute expected ready and next state from the behavioural rules.
    function automatic logic model_ready(input logic [1:0] sel, input logic [1:0] ordy);
        if (sel == 2'b00) return 1'b1;
        for (int i = 0; i < 2; i++)
            if (sel[i]) return !mv[i] || ordy[i];
        return 1'b1;
    endfunction

    task automatic model_step(input logic v, input logic [1:0] sel, input logic [31:0] data,
                              input logic [1:0] ordy);
        logic acc;
        int   w;
        acc = v && model_ready(sel, ordy);
        w = -1;
        for (int i = 1; i >= 0; i--) if (sel[i]) w = i;
        for (int i = 0; i < 2; i++) begin
            if (acc && w == i) begin
                mv[i] = 1'b1;
                md[i] = data;
            end else if (mv[i] && ordy[i]) begin
                mv[i] = 1'b0;
            end
        end
        mhit = acc && (w >= 0);
        if (acc && w < 0 && mdc < 3) mdc++;
    endtask

    initial begin
        // Directed table: one row per cycle, expectations after the edge.
        tbl[0]  = '{1'b1, 2'b11, 32'hA5A5A5A5, 2'b00, 1'b1, 2'b01, 1'b1, 32'hA5A5A5A5, 32'h0,  2'd0};
        tbl[1]  = '{1'b1, 2'b11, 32'h00000000, 2'b00, 1'b0, 2'b01, 1'b0, 32'hA5A5A5A5, 32'h0,  2'd0};
        tbl[2]  = '{1'b1, 2'b01, 32'h00000022, 2'b00, 1'b0, 2'b01, 1'b0, 32'hA5A5A5A5, 32'h0,  2'd0};
        tbl[3]  = '{1'b1, 2'b10, 32'h00000011, 2'b00, 1'b1, 2'b11, 1'b1, 32'hA5A5A5A5, 32'h11, 2'd0};
        tbl[4]  = '{1'b1, 2'b10, 32'h00000001, 2'b10, 1'b1, 2'b11, 1'b1, 32'hA5A5A5A5, 32'h1,  2'd0};
        tbl[5]  = '{1'b1, 2'b10, 32'h00000002, 2'b10, 1'b1, 2'b11, 1'b1, 32'hA5A5A5A5, 32'h2,  2'd0};
        tbl[6]  = '{1'b1, 2'b10, 32'h00000003, 2'b10, 1'b1, 2'b11, 1'b1, 32'hA5A5A5A5, 32'h3,  2'd0};
        tbl[7]  = '{1'b1, 2'b10, 32'h00000004, 2'b10, 1'b1, 2'b11, 1'b1, 32'hA5A5A5A5, 32'h4,  2'd0};
        tbl[8]  = '{1'b0, 2'b00, 32'h00000000, 2'b10, 1'b1, 2'b01, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd0};
        tbl[9]  = '{1'b0, 2'b00, 32'h00000000, 2'b11, 1'b1, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd0};
        tbl[10] = '{1'b1, 2'b00, 32'hDEAD0001, 2'b00, 1'b1, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd1};
        tbl[11] = '{1'b1, 2'b00, 32'hDEAD0002, 2'b00, 1'b1, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd2};
        tbl[12] = '{1'b1, 2'b00, 32'hDEAD0003, 2'b00, 1'b1, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd3};
        tbl[13] = '{1'b1, 2'b00, 32'hDEAD0004, 2'b00, 1'b1, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd3};
        tbl[14] = '{1'b1, 2'b00, 32'hDEAD0005, 2'b00, 1'b1, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h4,  2'd3};

        // Reset state, with a drop-eligible word presented to show ready is forced low.
        rst = 1'b1;
        drive(1'b1, 2'b00, 32'h0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready",   {63'h0, in_ready},   64'h0);
        chk("reset_out_valid",  {62'h0, out_valid},  64'h0);
        chk("reset_out_data",   out_data,            64'h0);
        chk("reset_hit",        {63'h0, hit},        64'h0);
        chk("reset_drop_count", {62'h0, drop_count}, 64'h0);
        rst = 1'b0;

        // Directed table.
        for (int r = 0; r < 15; r++) begin
            drive(tbl[r].v, tbl[r].sel, tbl[r].data, tbl[r].ordy);
            chk($sformatf("tbl%0d_in_ready", r), {63'h0, in_ready}, {63'h0, tbl[r].rdy});
            post_edge();
            chk($sformatf("tbl%0d_out_valid", r), {62'h0, out_valid},  {62'h0, tbl[r].ov});
            chk($sformatf("tbl%0d_hit", r),       {63'h0, hit},        {63'h0, tbl[r].hit});
            chk($sformatf("tbl%0d_data0", r),     {32'h0, out_data[31:0]},  {32'h0, tbl[r].d0});
            chk($sformatf("tbl%0d_data1", r),     {32'h0, out_data[63:32]}, {32'h0, tbl[r].d1});
            chk($sformatf("tbl%0d_drops", r),     {62'h0, drop_count}, {62'h0, tbl[r].dc});
            @(negedge clk);
        end

        // Random phase against the behavioural model, seeded from the table's end state.
        mv[0] = 1'b0; mv[1] = 1'b0;
        md[0] = 32'hA5A5A5A5; md[1] = 32'h4;
        mdc = 3; mhit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            logic        v;
            logic [1:0]  sel;
            logic [31:0] data;
            logic [1:0]  ordy;
            v    = ($urandom_range(0, 3) != 0);
            sel  = 2'($urandom_range(0, 3));
            data = $urandom;
            ordy = 2'($urandom_range(0, 3));
            drive(v, sel, data, ordy);
            chk($sformatf("rnd%0d_in_ready", k), {63'h0, in_ready}, {63'h0, model_ready(sel, ordy)});
            model_step(v, sel, data, ordy);
            post_edge();
            chk($sformatf("rnd%0d_out_valid", k), {62'h0, out_valid}, {62'h0, mv[1], mv[0]});
            chk($sformatf("rnd%0d_hit", k),       {63'h0, hit},       {63'h0, mhit});
            chk($sformatf("rnd%0d_data0", k),     {32'h0, out_data[31:0]},  {32'h0, md[0]});
            chk($sformatf("rnd%0d_data1", k),     {32'h0, out_data[63:32]}, {32'h0, md[1]});
            chk($sformatf("rnd%0d_drops", k),     {62'h0, drop_count}, 64'(mdc));
            @(negedge clk);
        end

        // Mid-operation reset with both slots full and stalled.
        drive(1'b0, 2'b00, 32'h0, 2'b11);
        post_edge(); @(negedge clk);
        drive(1'b1, 2'b01, 32'hC0C0C0C0, 2'b00);
        post_edge(); @(negedge clk);
        drive(1'b1, 2'b10, 32'hC1C1C1C1, 2'b00);
        post_edge(); @(negedge clk);
        chk("pre_rst_out_valid", {62'h0, out_valid}, 64'h3);
        drive(1'b0, 2'b00, 32'h0, 2'b00);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid",  {62'h0, out_valid},  64'h0);
        chk("async_rst_out_data",   out_data,            64'h0);
        chk("async_rst_drop_count", {62'h0, drop_count}, 64'h0);
        chk("async_rst_in_ready",   {63'h0, in_ready},   64'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b10, 32'h00000077, 2'b00);
        chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
        post_edge();
        chk("post_rst_out_valid", {62'h0, out_valid}, 64'h2);
        chk("post_rst_data1",     {32'h0, out_data[63:32]}, 64'h77);
        chk("post_rst_data0",     {32'h0, out_data[31:0]},  64'h0);
        chk("post_rst_hit",       {63'h0, hit}, 64'h1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
